// File: rtl/shifter_serializer.sv
// shifter_serializer: parallel-in, serial-out loader that drives a downstream shifter's D input.
// Build option SHIFTER_SERIALIZER_PARITY_EN appends an even-parity bit after the data bits.
//
// state | meaning
// IDLE  | line held low, waiting for LD (DONE pulses here after a frame)
// SHIFT | presenting data bits, one per C period
// PAR   | presenting the even-parity bit (parity build only)
module shifter_serializer #(
    parameter int WIDTH     = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic             C,
    input  logic             nR,
    input  logic [WIDTH-1:0] P,
    input  logic             LD,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SHIFTER_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shreg_rot;

    // Rotating keeps every loaded bit in the register, so parity can be taken at frame end.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shreg_rot = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        end else begin
            shreg_rot = {shreg_q[0], shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        so_d    = so_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                so_d   = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (LD) begin
                    state_d = ST_SHIFT;
                    shreg_d = P;
                    busy_d  = 1'b1;
                    so_d    = (MSB_FIRST != 0) ? P[WIDTH-1] : P[0];
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
`ifdef SHIFTER_SERIALIZER_PARITY_EN
                    state_d = ST_PAR;
                    so_d    = ^shreg_q;
`else
                    state_d = ST_IDLE;
                    so_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shreg_d = shreg_rot;
                    so_d    = (MSB_FIRST != 0) ? shreg_rot[WIDTH-1] : shreg_rot[0];
                end
            end
`ifdef SHIFTER_SERIALIZER_PARITY_EN
            ST_PAR: begin
                state_d = ST_IDLE;
                so_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                so_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SO   = so_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_shifter_serializer.sv
// Directed bench for shifter_serializer: LSB-first and MSB-first WIDTH=2 units, plus a WIDTH=5 unit.
// Parity-build expectations are selected by SHIFTER_SERIALIZER_PARITY_EN.
module tb_shifter_serializer;

    logic       C;
    logic       nR;
    logic [1:0] P;
    logic       LD;
    logic [4:0] P5;
    logic       LD5;
    logic       so_l, busy_l, done_l;
    logic       so_m, busy_m, done_m;
    logic       so_5, busy_5, done_5;
    logic       q0, q1;
    logic [4:0] exp5;
    int         n_tests;
    int         n_fail;

    shifter_serializer #(.WIDTH(2), .MSB_FIRST(0)) u_lsb (
        .C(C), .nR(nR), .P(P), .LD(LD), .SO(so_l), .BUSY(busy_l), .DONE(done_l)
    );

    shifter_serializer #(.WIDTH(2), .MSB_FIRST(1)) u_msb (
        .C(C), .nR(nR), .P(P), .LD(LD), .SO(so_m), .BUSY(busy_m), .DONE(done_m)
    );

    shifter_serializer #(.WIDTH(5), .MSB_FIRST(1)) u_w5 (
        .C(C), .nR(nR), .P(P5), .LD(LD5), .SO(so_5), .BUSY(busy_5), .DONE(done_5)
    );

    // Downstream 2-bit shifter fed by the MSB-first unit on the same clock.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            q0 <= 1'b0;
            q1 <= 1'b0;
        end else begin
            q0 <= so_m;
            q1 <= q0;
        end
    end

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nR      = 1'b0;
        LD      = 1'b0;
        P       = 2'b00;
        LD5     = 1'b0;
        P5      = 5'b00000;
        #3;
        chk("rst_lsb", {29'd0, so_l, busy_l, done_l}, 32'b000);
        chk("rst_w5",  {29'd0, so_5, busy_5, done_5}, 32'b000);
        tick();
        tick();
        nR = 1'b1;
        tick();

`ifndef SHIFTER_SERIALIZER_PARITY_EN
        // Frame P=01 on both WIDTH=2 units
        P  = 2'b01;
        LD = 1'b1;
        tick();
        LD = 1'b0;
        chk("t1_e0_lsb", {29'd0, so_l, busy_l, done_l}, 32'b110);
        chk("t2_e0_msb", {29'd0, so_m, busy_m, done_m}, 32'b010);
        tick();
        chk("t1_e1_lsb", {29'd0, so_l, busy_l, done_l}, 32'b010);
        chk("t2_e1_msb", {29'd0, so_m, busy_m, done_m}, 32'b110);
        tick();
        chk("t1_e2_lsb", {29'd0, so_l, busy_l, done_l}, 32'b001);
        chk("t2_e2_msb", {29'd0, so_m, busy_m, done_m}, 32'b001);
        chk("t2_shifter_q1q0", {30'd0, q1, q0}, 32'b01);
        tick();
        chk("t1_e3_lsb", {29'd0, so_l, busy_l, done_l}, 32'b000);
        tick();

        // LD held high: back-to-back frames every 3 cycles
        P  = 2'b10;
        LD = 1'b1;
        tick();
        chk("t3_f1_b0", {29'd0, so_l, busy_l, done_l}, 32'b010);
        P = 2'b11;
        tick();
        chk("t3_f1_b1", {29'd0, so_l, busy_l, done_l}, 32'b110);
        tick();
        chk("t3_f1_done", {29'd0, so_l, busy_l, done_l}, 32'b001);
        tick();
        chk("t3_f2_b0", {29'd0, so_l, busy_l, done_l}, 32'b110);
        tick();
        chk("t3_f2_b1", {29'd0, so_l, busy_l, done_l}, 32'b110);
        LD = 1'b0;
        tick();
        chk("t3_f2_done", {29'd0, so_l, busy_l, done_l}, 32'b001);
        tick();
        chk("t3_idle", {29'd0, so_l, busy_l, done_l}, 32'b000);

        // LD and P change while busy must not disturb the frame
        P  = 2'b10;
        LD = 1'b1;
        tick();
        P = 2'b01;
        chk("t4_b0", {29'd0, so_l, busy_l, done_l}, 32'b010);
        tick();
        LD = 1'b0;
        chk("t4_b1", {29'd0, so_l, busy_l, done_l}, 32'b110);
        tick();
        chk("t4_done", {29'd0, so_l, busy_l, done_l}, 32'b001);
        tick();
        chk("t4_no_reload", {29'd0, so_l, busy_l, done_l}, 32'b000);
        tick();
        chk("t4_no_extra_done", {29'd0, so_l, busy_l, done_l}, 32'b000);
`else
        // Parity frames
        P  = 2'b01;
        LD = 1'b1;
        tick();
        LD = 1'b0;
        chk("t6a_b0", {29'd0, so_l, busy_l, done_l}, 32'b110);
        tick();
        chk("t6a_b1", {29'd0, so_l, busy_l, done_l}, 32'b010);
        tick();
        chk("t6a_par", {29'd0, so_l, busy_l, done_l}, 32'b110);
        tick();
        chk("t6a_done", {29'd0, so_l, busy_l, done_l}, 32'b001);
        tick();
        chk("t6a_idle", {29'd0, so_l, busy_l, done_l}, 32'b000);
        P  = 2'b11;
        LD = 1'b1;
        tick();
        LD = 1'b0;
        chk("t6b_b0", {29'd0, so_l, busy_l, done_l}, 32'b110);
        tick();
        chk("t6b_b1", {29'd0, so_l, busy_l, done_l}, 32'b110);
        tick();
        chk("t6b_par", {29'd0, so_l, busy_l, done_l}, 32'b010);
        tick();
        chk("t6b_done", {29'd0, so_l, busy_l, done_l}, 32'b001);
        tick();
        chk("t6b_idle", {29'd0, so_l, busy_l, done_l}, 32'b000);
`endif

        // WIDTH=5 MSB-first frame: bits 1,0,1,1,0
        exp5 = 5'b10110;
        P5   = exp5;
        LD5  = 1'b1;
        tick();
        LD5 = 1'b0;
        P5  = 5'b01001;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("w5_bit%0d", i), {30'd0, so_5, busy_5}, {30'd0, exp5[4-i], 1'b1});
            tick();
        end
`ifdef SHIFTER_SERIALIZER_PARITY_EN
        chk("w5_par", {29'd0, so_5, busy_5, done_5}, 32'b110);
        tick();
`endif
        chk("w5_done", {29'd0, so_5, busy_5, done_5}, 32'b001);
        tick();
        chk("w5_idle", {29'd0, so_5, busy_5, done_5}, 32'b000);

        // Asynchronous reset during bit 1
        P  = 2'b11;
        LD = 1'b1;
        tick();
        LD = 1'b0;
        tick();
        chk("t5_pre_rst", {29'd0, so_l, busy_l, done_l}, 32'b110);
        #2;
        nR = 1'b0;
        #1;
        chk("t5_async_rst", {29'd0, so_l, busy_l, done_l}, 32'b000);
        tick();
        nR = 1'b1;
        tick();
        tick();
        chk("t5_after_release", {29'd0, so_l, busy_l, done_l}, 32'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
